// File: rtl/mips_pkg.sv
// mips_pkg: shared memory-access encodings and helpers for the MIPS pipeline.
package mips_pkg;

  localparam int DM_WORDS = 1024;

  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_HALF = 2'b01,
    MEM_BYTE = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  // Reserved size behaves exactly like a word access.
  function automatic logic misaligned(input mem_size_e sz, input logic [1:0] a);
    return sz == MEM_HALF ? a[0] : sz == MEM_BYTE ? 1'b0 : |a;
  endfunction

  function automatic logic [3:0] byte_en(input mem_size_e sz, input logic [1:0] a);
    return sz == MEM_HALF ? (a[1] ? 4'b1100 : 4'b0011)
         : sz == MEM_BYTE ? 4'b0001 << a
         : 4'b1111;
  endfunction

  function automatic logic [31:0] store_lanes(input mem_size_e sz, input logic [31:0] d);
    return sz == MEM_HALF ? {2{d[15:0]}} : sz == MEM_BYTE ? {4{d[7:0]}} : d;
  endfunction

endpackage

// File: rtl/mem_stage_dm.sv
// dm: word-organised data memory with async read, byte-enable write and async clear.
module dm #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < 4; b++) if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage - EX/MEM register, aligned sub-word loads/stores, load formatting.
module mem_stage
  import mips_pkg::*;
#(
  parameter int DM_WORDS = mips_pkg::DM_WORDS,
  parameter int DM_AW    = $clog2(DM_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUOut,
  input  logic [31:0] WriteData_E,
  input  logic [4:0]  WriteReg_E,
  input  logic        RegWrite_E,
  input  logic        MemtoReg_E,
  input  logic        MemWrite_E,
  input  logic        MemRead_E,
  input  logic [1:0]  MemSize_E,
  input  logic        MemSign_E,
  output logic [31:0] ALU_O_M,
  output logic [4:0]  WriteReg_M,
  output logic        RegWrite_M,
  output logic        MemtoReg_M,
  output logic [31:0] ReadData_M,
  output logic        AddrErr_M
);

  logic [31:0] alu_q, wd_q;
  logic [4:0]  wr_q;
  logic        rw_q, m2r_q, mw_q, mr_q, sign_q;
  mem_size_e   size_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_q  <= '0;
      wd_q   <= '0;
      wr_q   <= '0;
      rw_q   <= 1'b0;
      m2r_q  <= 1'b0;
      mw_q   <= 1'b0;
      mr_q   <= 1'b0;
      sign_q <= 1'b0;
      size_q <= MEM_WORD;
    end else begin
      alu_q  <= ALUOut;
      wd_q   <= WriteData_E;
      wr_q   <= WriteReg_E;
      rw_q   <= RegWrite_E;
      m2r_q  <= MemtoReg_E;
      mw_q   <= MemWrite_E;
      mr_q   <= MemRead_E;
      sign_q <= MemSign_E;
      size_q <= mem_size_e'(MemSize_E);
    end
  end

  logic        mis;
  logic [31:0] raw;
  logic [15:0] half;
  logic [7:0]  lane;
  logic [31:0] load_v;

  assign mis = misaligned(size_q, alu_q[1:0]);

  dm #(.WORDS(DM_WORDS), .AW(DM_AW)) u_dm (
    .clk     (clk),
    .rst     (reset),
    .addr_i  (alu_q[DM_AW+1:2]),
    .we_i    (mw_q & ~mis),
    .be_i    (byte_en(size_q, alu_q[1:0])),
    .wdata_i (store_lanes(size_q, wd_q)),
    .rdata_o (raw)
  );

  always_comb begin
    half   = alu_q[1] ? raw[31:16] : raw[15:0];
    lane   = raw[8*alu_q[1:0] +: 8];
    load_v = size_q == MEM_HALF ? {{16{sign_q & half[15]}}, half}
           : size_q == MEM_BYTE ? {{24{sign_q & lane[7]}}, lane}
           : raw;
  end

  // Reads see pre-write contents, so a combined read/write returns the old word.
  assign ReadData_M = reset ? '0 : !mr_q ? raw : mis ? '0 : load_v;
  assign ALU_O_M    = alu_q;
  assign WriteReg_M = wr_q;
  assign RegWrite_M = rw_q & ~(mr_q & mis);
  assign MemtoReg_M = m2r_q;
  assign AddrErr_M  = mis & (mr_q | mw_q);

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: random and directed checks of mem_stage against a byte-array memory model.
module tb_mem_stage;

  localparam int W = 1024;

  logic        clk = 1'b0, reset;
  logic [31:0] ALUOut, WriteData_E;
  logic [4:0]  WriteReg_E;
  logic        RegWrite_E, MemtoReg_E, MemWrite_E, MemRead_E, MemSign_E;
  logic [1:0]  MemSize_E;
  logic [31:0] ALU_O_M, ReadData_M;
  logic [4:0]  WriteReg_M;
  logic        RegWrite_M, MemtoReg_M, AddrErr_M;

  mem_stage #(.DM_WORDS(W), .DM_AW(10)) dut (
    .clk(clk), .reset(reset), .ALUOut(ALUOut), .WriteData_E(WriteData_E),
    .WriteReg_E(WriteReg_E), .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E),
    .MemWrite_E(MemWrite_E), .MemRead_E(MemRead_E), .MemSize_E(MemSize_E),
    .MemSign_E(MemSign_E), .ALU_O_M(ALU_O_M), .WriteReg_M(WriteReg_M),
    .RegWrite_M(RegWrite_M), .MemtoReg_M(MemtoReg_M), .ReadData_M(ReadData_M),
    .AddrErr_M(AddrErr_M)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [7:0] mm [W*4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < W*4; i++) mm[i] = 8'h00;
  endtask

  function automatic logic is_aligned(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'b10) return 1'b1;
    if (sz == 2'b01) return a[0] == 1'b0;
    return a[1:0] == 2'b00;
  endfunction

  function automatic int base_of(input logic [31:0] a);
    return (int'(a >> 2) % W) * 4;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_alu"}, ALU_O_M, 32'h0);
    chk({tag, "_wreg"}, {27'b0, WriteReg_M}, 32'h0);
    chk({tag, "_rw"}, {31'b0, RegWrite_M}, 32'h0);
    chk({tag, "_m2r"}, {31'b0, MemtoReg_M}, 32'h0);
    chk({tag, "_aerr"}, {31'b0, AddrErr_M}, 32'h0);
    chk({tag, "_rdata"}, ReadData_M, 32'h0);
  endtask

  // Drives one instruction, checks it in M, then commits its store to the model.
  task automatic op(input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                    input logic rw, input logic m2r, input logic mw, input logic mr,
                    input logic [1:0] sz, input logic sg);
    int base, off;
    logic al;
    logic [31:0] w, e;
    logic [15:0] h;
    logic [7:0] b;
    ALUOut = a; WriteData_E = d; WriteReg_E = r; RegWrite_E = rw; MemtoReg_E = m2r;
    MemWrite_E = mw; MemRead_E = mr; MemSize_E = sz; MemSign_E = sg;
    @(posedge clk);
    #1;
    base = base_of(a);
    al = is_aligned(a, sz);
    w = {mm[base+3], mm[base+2], mm[base+1], mm[base]};
    if (!mr) e = w;
    else if (!al) e = 32'h0;
    else if (sz == 2'b10) begin
      b = mm[base + int'(a[1:0])];
      e = sg ? 32'($signed(b)) : {24'b0, b};
    end else if (sz == 2'b01) begin
      off = a[1] ? 2 : 0;
      h = {mm[base+off+1], mm[base+off]};
      e = sg ? 32'($signed(h)) : {16'b0, h};
    end else e = w;
    chk("alu", ALU_O_M, a);
    chk("wreg", {27'b0, WriteReg_M}, {27'b0, r});
    chk("rw", {31'b0, RegWrite_M}, {31'b0, rw && !(mr && !al)});
    chk("m2r", {31'b0, MemtoReg_M}, {31'b0, m2r});
    chk("aerr", {31'b0, AddrErr_M}, {31'b0, !al && (mr || mw)});
    chk("rdata", ReadData_M, e);
    if (mw && al) begin
      if (sz == 2'b10) mm[base + int'(a[1:0])] = d[7:0];
      else if (sz == 2'b01) begin
        off = a[1] ? 2 : 0;
        mm[base+off] = d[7:0];
        mm[base+off+1] = d[15:8];
      end else for (int i = 0; i < 4; i++) mm[base+i] = d[8*i +: 8];
    end
  endtask

  initial begin
    logic [31:0] r, d;
    clear_model();
    reset = 1'b1;
    ALUOut = '0; WriteData_E = '0; WriteReg_E = '0; RegWrite_E = 0; MemtoReg_E = 0;
    MemWrite_E = 0; MemRead_E = 0; MemSize_E = 0; MemSign_E = 0;
    #1;
    check_zero("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    op(32'h10, 32'h12345678, 5'd0, 0, 0, 1, 0, 2'b00, 0);
    op(32'h10, 32'h0, 5'd3, 1, 1, 0, 1, 2'b00, 0);
    chk("tp_lw", ReadData_M, 32'h12345678);
    op(32'h13, 32'h80, 5'd0, 0, 0, 1, 0, 2'b10, 0);
    op(32'h13, 32'h0, 5'd4, 1, 1, 0, 1, 2'b10, 1);
    chk("tp_lb", ReadData_M, 32'hFFFFFF80);
    op(32'h13, 32'h0, 5'd4, 1, 1, 0, 1, 2'b10, 0);
    chk("tp_lbu", ReadData_M, 32'h00000080);
    op(32'h10, 32'h0, 5'd4, 1, 1, 0, 1, 2'b00, 0);
    chk("tp_lw_merged", ReadData_M, 32'h80345678);
    op(32'h22, 32'h1234BEEF, 5'd0, 0, 0, 1, 0, 2'b01, 0);
    op(32'h22, 32'h0, 5'd5, 1, 1, 0, 1, 2'b01, 1);
    chk("tp_lh", ReadData_M, 32'hFFFFBEEF);
    op(32'h20, 32'h0, 5'd5, 1, 1, 0, 1, 2'b01, 0);
    chk("tp_lhu_low", ReadData_M, 32'h00000000);
    op(32'h06, 32'h0, 5'd6, 1, 1, 0, 1, 2'b00, 0);
    chk("tp_mis_aerr", {31'b0, AddrErr_M}, 32'h1);
    chk("tp_mis_rw", {31'b0, RegWrite_M}, 32'h0);
    op(32'h05, 32'hFFFF, 5'd0, 0, 0, 1, 0, 2'b01, 0);
    op(32'h04, 32'h0, 5'd6, 1, 1, 0, 1, 2'b00, 0);
    chk("tp_mis_sh_nowrite", ReadData_M, 32'h0);
    op(32'hABCD0004, 32'h0, 5'd7, 1, 0, 0, 0, 2'b00, 0);
    chk("tp_alu_fwd", ALU_O_M, 32'hABCD0004);
    op(32'h1004, 32'hCAFEF00D, 5'd0, 0, 0, 1, 0, 2'b00, 0);
    op(32'h04, 32'h0, 5'd8, 1, 1, 0, 1, 2'b00, 0);
    chk("tp_alias", ReadData_M, 32'hCAFEF00D);

    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      d = $urandom;
      if (n % 17 == 0) op(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 2'b00, 0);
      else op({r[31:12], 4'b0000, r[7:0]}, d, 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    op(32'h30, 32'h55AA55AA, 5'd0, 1, 0, 1, 0, 2'b00, 0);
    #1;
    reset = 1'b1;
    #1;
    check_zero("rst_mid");
    clear_model();
    @(posedge clk);
    #1;
    reset = 1'b0;
    op(32'h30, 32'h0, 5'd9, 1, 1, 0, 1, 2'b00, 0);
    chk("tp_rst_store_dropped", ReadData_M, 32'h0);
    op(32'h10, 32'h0, 5'd9, 1, 1, 0, 1, 2'b00, 0);
    chk("tp_rst_mem_cleared", ReadData_M, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
